// File: rtl/glb_bank_stream_reader.sv
// Sequential bank read initiator: issues credit-gated reads into a fixed-latency bank port and streams responses out.
// Optional abort support is compiled in with GLB_RD_ABORT_EN (adds cfg_abort).
module glb_bank_stream_reader #(
    parameter int BANK_ADDR_WIDTH  = 17,
    parameter int BANK_DATA_WIDTH  = 64,
    parameter int BANK_BYTE_OFFSET = 3,
    parameter int RD_LATENCY       = 3,
    parameter int FIFO_DEPTH       = 4,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cfg_start,
    input  logic [BANK_ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [CNT_WIDTH-1:0]       cfg_num_words,
`ifdef GLB_RD_ABORT_EN
    input  logic                       cfg_abort,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       bank_ren,
    output logic                       bank_wen,
    output logic [BANK_ADDR_WIDTH-1:0] bank_addr,
    input  logic [BANK_DATA_WIDTH-1:0] bank_data_out,
    output logic [BANK_DATA_WIDTH-1:0] rd_data,
    output logic                       rd_data_valid,
    input  logic                       rd_data_ready,
    output logic [1:0]                 dbg_state
);
    localparam int WAW = BANK_ADDR_WIDTH - BANK_BYTE_OFFSET;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int SW  = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

    logic [1:0]                 state_q, state_d;
    logic [CNT_WIDTH-1:0]       remaining_q, remaining_d, remaining_base;
    logic [WAW-1:0]             word_addr_q, word_addr_d;
    logic                       bank_ren_q, bank_ren_d;
    logic [BANK_ADDR_WIDTH-1:0] bank_addr_q, bank_addr_d;
    logic [RD_LATENCY-1:0]      pipe_q, pipe_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                count_q, count_d;
    logic                       drop_q, drop_d;
    logic [BANK_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                       push, pop, abort_now;
    logic [SW-1:0]              committed;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^cfg_start_addr[BANK_BYTE_OFFSET-1:0];

`ifdef GLB_RD_ABORT_EN
    assign abort_now = cfg_abort && (state_q == S_ISSUE || state_q == S_DRAIN);
`else
    assign abort_now = 1'b0;
`endif

    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign bank_ren      = bank_ren_q;
    assign bank_wen      = 1'b0;
    assign bank_addr     = bank_addr_q;
    assign rd_data_valid = (count_q != '0);
    assign rd_data       = rd_data_valid ? mem_q[rd_ptr_q] : '0;
    assign dbg_state     = state_q;

    always_comb begin
        pop  = rd_data_valid && rd_data_ready;
        push = pipe_q[RD_LATENCY-1] && !drop_q && !abort_now;

        pipe_d[0] = bank_ren_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (!push && pop) count_d = count_q - CNT_ONE;
        if (abort_now) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        state_d        = state_q;
        remaining_base = remaining_q;
        word_addr_d    = word_addr_q;
        drop_d         = drop_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    word_addr_d    = cfg_start_addr[BANK_ADDR_WIDTH-1:BANK_BYTE_OFFSET];
                    remaining_base = cfg_num_words;
                    state_d        = (cfg_num_words == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (remaining_q == '0) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pipe_q == '0 && !bank_ren_q && count_q == '0) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
        if (abort_now) begin
            state_d        = S_DRAIN;
            remaining_base = '0;
            drop_d         = 1'b1;
        end

        // Credit for next cycle's read: everything already owed a FIFO slot after this edge.
        committed = SW'(count_d);
        for (int i = 0; i < RD_LATENCY; i++) begin
            committed = committed + SW'(pipe_d[i]);
        end

        bank_ren_d  = (state_d == S_ISSUE) && (remaining_base != '0) && (committed < DEPTH_S);
        remaining_d = remaining_base - CNT_WIDTH'(bank_ren_d);
        bank_addr_d = bank_addr_q;
        if (bank_ren_d) begin
            bank_addr_d = {word_addr_d, {BANK_BYTE_OFFSET{1'b0}}};
            word_addr_d = word_addr_d + WAW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            word_addr_q <= '0;
            bank_ren_q  <= 1'b0;
            bank_addr_q <= '0;
            pipe_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            word_addr_q <= word_addr_d;
            bank_ren_q  <= bank_ren_d;
            bank_addr_q <= bank_addr_d;
            pipe_q      <= pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bank_data_out;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && count_q == CNT_MAX));

endmodule

// File: tb/tb_glb_bank_stream_reader.sv
// Directed bench for glb_bank_stream_reader: bank latency model, stream scoreboard, per-scenario tasks.
`timescale 1ns/1ps
module tb_glb_bank_stream_reader;
    localparam int AW  = 17;
    localparam int DW  = 64;
    localparam int LAT = 3;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_start_addr = '0;
    logic [CW-1:0] cfg_num_words = '0;
`ifdef GLB_RD_ABORT_EN
    logic          cfg_abort = 1'b0;
`endif
    logic          busy, done, bank_ren, bank_wen, rd_data_valid;
    logic          rd_data_ready = 1'b0;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_data_out, rd_data;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad = 0;
    int ren_count = 0;
    int pop_count = 0;
    int done_count = 0;
    bit busy_seen = 1'b0;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] exp_q[$];

    logic          stage_v [LAT];
    logic [AW-1:0] stage_a [LAT];

    glb_bank_stream_reader dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start),
        .cfg_start_addr(cfg_start_addr), .cfg_num_words(cfg_num_words),
`ifdef GLB_RD_ABORT_EN
        .cfg_abort(cfg_abort),
`endif
        .busy(busy), .done(done), .bank_ren(bank_ren), .bank_wen(bank_wen),
        .bank_addr(bank_addr), .bank_data_out(bank_data_out), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {16'hC0DE, 15'h0, a, 16'h5A5A};
    endfunction

    // Bank model: data for a read in cycle t is on bank_data_out during cycle t+LAT.
    always @(posedge clk) begin
        stage_v[0] <= bank_ren;
        stage_a[0] <= bank_addr;
        for (int k = 1; k < LAT; k++) begin
            stage_v[k] <= stage_v[k-1];
            stage_a[k] <= stage_a[k-1];
        end
    end
    assign bank_data_out = (stage_v[LAT-1] === 1'b1) ? mem_word(stage_a[LAT-1]) : 64'hDEAD_BEEF_0BAD_F00D;

    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            if (bank_wen !== 1'b0) begin
                bad++;
                $display("FAIL bank_wen: got %b want 0", bank_wen);
            end
            if (bank_ren === 1'b1) begin
                ren_count++;
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ren: addr %h with no read expected", bank_addr);
                end else begin
                    logic [AW-1:0] ea;
                    ea = addr_q.pop_front();
                    if (bank_addr !== ea) begin
                        bad++;
                        $display("FAIL bank_addr: got %h want %h", bank_addr, ea);
                    end
                end
            end
            if (rd_data_valid === 1'b1 && rd_data_ready === 1'b1) begin
                pop_count++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pop: data %h with none expected", rd_data);
                end else begin
                    logic [DW-1:0] ed;
                    ed = exp_q.pop_front();
                    if (rd_data !== ed) begin
                        bad++;
                        $display("FAIL rd_data: got %h want %h", rd_data, ed);
                    end
                end
            end
            if (done === 1'b1) done_count++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        ren_count  = 0;
        pop_count  = 0;
        done_count = 0;
        busy_seen  = 1'b0;
    endtask

    task automatic expect_seq(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i * 8);
            addr_q.push_back(a);
            exp_q.push_back(mem_word(a));
        end
    endtask

    task automatic start_xfer(input logic [AW-1:0] a, input logic [CW-1:0] n);
        @(posedge clk); #1;
        cfg_start      = 1'b1;
        cfg_start_addr = a;
        cfg_num_words  = n;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_done_timeout: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({busy, done, bank_ren, bank_wen, rd_data_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, bank_ren, bank_wen, rd_data_valid});
        end
        total++;
        if (bank_addr !== '0 || rd_data !== '0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: addr %h data %h state %0d want all 0", bank_addr, rd_data, dbg_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        clear_counts();
        rd_data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr_q.push_back(17'h00100 + AW'(i * 8));
            exp_q.push_back(mem_word(17'h00100 + AW'(i * 8)));
        end
        start_xfer(17'h00100, 16'd8);
        total++;
        if (bank_ren !== 1'b1 || bank_addr !== 17'h00100 || dbg_state !== 2'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_first_read: ren %b addr %h state %0d busy %b want 1 00100 1 1",
                     bank_ren, bank_addr, dbg_state, busy);
        end
        wait_done(100, "basic");
        check_int("basic_done_count", done_count, 1);
        @(negedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_width: done %b busy %b want 0 0", done, busy);
        end
        check_int("basic_reads", ren_count, 8);
        check_int("basic_pops", pop_count, 8);
        check_int("basic_left", exp_q.size() + addr_q.size(), 0);
    endtask

    task automatic test_backpressure();
        clear_counts();
        rd_data_ready = 1'b0;
        expect_seq(17'h00400, 6);
        start_xfer(17'h00400, 16'd6);
        repeat (20) @(negedge clk);
        #1;
        check_int("bp_reads_stalled", ren_count, 4);
        total++;
        if (bank_ren !== 1'b0 || rd_data_valid !== 1'b1 || rd_data !== mem_word(17'h00400)) begin
            bad++;
            $display("FAIL bp_hold: ren %b valid %b data %h want 0 1 %h",
                     bank_ren, rd_data_valid, rd_data, mem_word(17'h00400));
        end
        @(posedge clk); #1;
        rd_data_ready = 1'b1;
        wait_done(100, "bp");
        check_int("bp_reads", ren_count, 6);
        check_int("bp_pops", pop_count, 6);
        check_int("bp_left", exp_q.size(), 0);
    endtask

    task automatic test_wrap();
        clear_counts();
        rd_data_ready = 1'b1;
        addr_q.push_back(17'h1FFF8); exp_q.push_back(mem_word(17'h1FFF8));
        addr_q.push_back(17'h00000); exp_q.push_back(mem_word(17'h00000));
        addr_q.push_back(17'h00008); exp_q.push_back(mem_word(17'h00008));
        start_xfer(17'h1FFF8, 16'd3);
        wait_done(60, "wrap");
        check_int("wrap_reads", ren_count, 3);
        check_int("wrap_left", exp_q.size() + addr_q.size(), 0);
        clear_counts();
        addr_q.push_back(17'h00200); exp_q.push_back(mem_word(17'h00200));
        addr_q.push_back(17'h00208); exp_q.push_back(mem_word(17'h00208));
        start_xfer(17'h00205, 16'd2);
        wait_done(60, "lowbits");
        check_int("lowbits_pops", pop_count, 2);
        check_int("lowbits_left", exp_q.size() + addr_q.size(), 0);
    endtask

    task automatic test_zero_and_ignore();
        clear_counts();
        rd_data_ready = 1'b1;
        start_xfer(17'h00300, 16'd0);
        @(negedge clk); #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: done %b busy %b want 1 0", done, busy);
        end
        @(negedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_done_width: done %b want 0", done);
        end
        repeat (3) @(negedge clk);
        #1;
        check_int("zero_reads", ren_count, 0);
        check_int("zero_busy_seen", int'(busy_seen), 0);
        check_int("zero_done_count", done_count, 1);

        clear_counts();
        rd_data_ready = 1'b0;
        expect_seq(17'h00500, 4);
        start_xfer(17'h00500, 16'd4);
        repeat (2) @(posedge clk);
        #1;
        cfg_start      = 1'b1;
        cfg_start_addr = 17'h00700;
        cfg_num_words  = 16'd9;
        @(posedge clk); #1;
        cfg_start     = 1'b0;
        rd_data_ready = 1'b1;
        wait_done(100, "ignore");
        repeat (3) @(negedge clk);
        #1;
        check_int("ignore_reads", ren_count, 4);
        check_int("ignore_pops", pop_count, 4);
        check_int("ignore_done_count", done_count, 1);
    endtask

    task automatic test_random_ready();
        bit seen;
        clear_counts();
        expect_seq(17'h03000, 100);
        start_xfer(17'h03000, 16'd100);
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rd_data_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        rd_data_ready = 1'b1;
        check_int("rand_done_seen", int'(seen), 1);
        check_int("rand_reads", ren_count, 100);
        check_int("rand_pops", pop_count, 100);
        check_int("rand_left", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid();
        clear_counts();
        rd_data_ready = 1'b1;
        expect_seq(17'h00800, 20);
        start_xfer(17'h00800, 16'd20);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, bank_ren, bank_wen, rd_data_valid} !== 5'b0 || bank_addr !== '0 ||
            rd_data !== '0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL midreset_outputs: ctrl %b addr %h data %h state %0d want all 0",
                     {busy, done, bank_ren, bank_wen, rd_data_valid}, bank_addr, rd_data, dbg_state);
        end
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_counts();
        expect_seq(17'h00040, 2);
        start_xfer(17'h00040, 16'd2);
        wait_done(60, "recover");
        check_int("recover_pops", pop_count, 2);
        check_int("recover_left", exp_q.size() + addr_q.size(), 0);
    endtask

`ifdef GLB_RD_ABORT_EN
    task automatic test_abort();
        int frozen;
        clear_counts();
        rd_data_ready = 1'b1;
        expect_seq(17'h01000, 50);
        start_xfer(17'h01000, 16'd50);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (ren_count >= 10) break;
        end
        check_int("abort_reached_10", ren_count, 10);
        @(posedge clk); #1;
        cfg_abort = 1'b1;
        @(negedge clk); #1;
        frozen = ren_count;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        exp_q.delete();
        addr_q.delete();
        total++;
        if (rd_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_flush: valid %b want 0", rd_data_valid);
        end
        wait_done(LAT + 2, "abort");
        repeat (4) @(negedge clk);
        #1;
        check_int("abort_no_more_reads", ren_count, frozen);
        check_int("abort_done_count", done_count, 1);
        clear_counts();
        expect_seq(17'h02000, 2);
        start_xfer(17'h02000, 16'd2);
        wait_done(60, "post_abort");
        check_int("post_abort_pops", pop_count, 2);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_ignore();
        test_random_ready();
        test_reset_mid();
`ifdef GLB_RD_ABORT_EN
        test_abort();
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
